// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the write-port arbiter.
package regfile_pkg;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;
    localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          hold,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_vld
);
    logic [PW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        if (!hold) begin
            for (int k = 0; k < N; k++) begin
                idx = PW'((int'(ptr) + k) % N);
                if (!grant_vld && req[idx]) begin
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                    grant_vld  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file's single write port with a registered output stage.
// Define REGFILE_R0_PROTECT_EN to accept but never write requests that target R0.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter int DATA_W  = regfile_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         Register_Destination,
    output logic [DATA_W-1:0]         data_in,
    output logic [2:0]                grant_id
);
    import regfile_pkg::*;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]     gidx;
    logic              gvld;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Holding the arbiter during reset keeps req_ready low asynchronously.
    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .hold      (wr_hold | ~rst),
        .grant     (grant),
        .grant_idx (gidx),
        .grant_vld (gvld)
    );

    assign req_ready = grant;
    assign sel_addr  = req_addr[gidx*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[gidx*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr               <= '0;
            RegWrite             <= 1'b0;
            Register_Destination <= '0;
            data_in              <= '0;
            grant_id             <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (gvld) begin
                rr_ptr               <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                Register_Destination <= sel_addr;
                data_in              <= sel_data;
                grant_id             <= 3'(gidx);
`ifdef REGFILE_R0_PROTECT_EN
                // Handshake still completes so the requester drains; only the write is suppressed.
                RegWrite             <= (sel_addr != ADDR_W'(REG_ZERO));
`else
                RegWrite             <= 1'b1;
`endif
            end
        end
    end
endmodule
